// File: rtl/mem_pkg.sv
// Shared memory-side constants and response type, also imported by the cache fill FSM.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W  = 16;
  localparam int unsigned MEM_DATA_W  = 16;
  localparam int unsigned MEM_LATENCY = 4;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-latency, never-stalling delay line for read responses, with synchronous clear.
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = MEM_LATENCY
) (
  input  logic      clk_i,
  input  logic      clear_i,
  input  mem_resp_t resp_i,
  output mem_resp_t resp_o,
  output logic      busy_o
);

  mem_resp_t stage_q [LATENCY];
  logic      busy_q;
  logic      busy_d;

  // Busy next cycle if the incoming slot or any stage that survives the shift holds a read.
  always_comb begin
    busy_d = resp_i.valid;
    for (int i = 0; i < int'(LATENCY) - 1; i++) begin
      busy_d = busy_d | stage_q[i].valid;
    end
  end

  // Shift every cycle; clear drops all in-flight responses.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
      busy_q <= 1'b0;
    end else begin
      stage_q[0] <= resp_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      busy_q <= busy_d;
    end
  end

  assign resp_o = stage_q[LATENCY-1];
  assign busy_o = busy_q;

endmodule

// File: rtl/memory_burst_responder.sv
// Word-addressed memory model answering cache-fill requests with a fixed read latency.
module memory_burst_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned DEPTH_LOG2 = 13,
  parameter int unsigned LATENCY    = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] memory_data,
  output logic              memory_data_valid,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  wr_req;
  logic                  rd_req;
  mem_resp_t             issue;
  mem_resp_t             final_resp;
  logic                  unused_addr;

  // Byte bit and bits above the array index are dropped, so upper addresses alias.
  assign word_idx    = address[DEPTH_LOG2:1];
  assign unused_addr = ^{address[ADDR_W-1:DEPTH_LOG2+1], address[0]};

  // Requests on a reset edge are ignored entirely.
  assign wr_req = enable & wr & ~rst;
  assign rd_req = enable & ~wr & ~rst;

  // Snapshot read data at issue; bubbles carry zero data so the output never shows stale words.
  always_comb begin
    issue = '0;
    if (rd_req) begin
      issue.valid = 1'b1;
      issue.data  = mem_q[word_idx];
    end
  end

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      mem_q[word_idx] <= data_in;
    end
  end

  mem_delay_pipe #(
    .LATENCY(LATENCY)
  ) u_delay_pipe (
    .clk_i  (clk),
    .clear_i(rst),
    .resp_i (issue),
    .resp_o (final_resp),
    .busy_o (busy)
  );

  assign memory_data       = final_resp.data;
  assign memory_data_valid = final_resp.valid;

endmodule

// File: tb/tb_memory_burst_responder.sv
// Directed and random traffic against a cycle-scheduled reference of the memory responder.
module tb_memory_burst_responder;

  localparam int unsigned Lat = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // Reference: word store plus responses keyed by the edge after which they appear.
  logic [15:0] ref_mem [int];
  logic [15:0] pending [int];

  always #5 clk = ~clk;

  memory_burst_responder #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .DEPTH_LOG2(13),
    .LATENCY   (Lat)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .wr               (wr),
    .address          (address),
    .data_in          (data_in),
    .memory_data      (memory_data),
    .memory_data_valid(memory_data_valid),
    .busy             (busy)
  );

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) / 2) % 8192;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock: drive, clock, update reference, then sample outputs away from the edge.
  task automatic step(input logic r, input logic en, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_b;
    rst     = r;
    enable  = en;
    wr      = w;
    address = a;
    data_in = d;
    @(posedge clk);
    edge_n++;
    if (r) begin
      pending.delete();
    end else if (en && w) begin
      ref_mem[word_of(a)] = d;
    end else if (en) begin
      pending[edge_n + int'(Lat) - 1] = ref_mem[word_of(a)];
    end
    #1;
    exp_v = pending.exists(edge_n);
    exp_d = exp_v ? pending[edge_n] : 16'h0000;
    exp_b = (pending.num() > 0);
    if (exp_v) pending.delete(edge_n);
    check_eq("valid", {31'd0, memory_data_valid}, {31'd0, exp_v});
    check_eq("data", {16'd0, memory_data}, {16'd0, exp_d});
    check_eq("busy", {31'd0, busy}, {31'd0, exp_b});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wr_op(input logic [15:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_op(input logic [15:0] a);
    step(1'b0, 1'b1, 1'b0, a, 16'hDEAD);
  endtask

  initial begin
    logic [15:0] a;
    rst = 1'b1; enable = 1'b0; wr = 1'b0; address = '0; data_in = '0;

    // Reset, with a write request on the reset edge that must be ignored.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0080, 16'h5555);
    idle(1);

    // Preload a 64-word window so every later read hits a known word.
    for (int i = 0; i < 64; i++) wr_op(16'(i * 2), 16'($urandom));
    // Reset-edge write must not have landed: word 0x0080 is outside the window, rewrite then read.
    wr_op(16'h0080, 16'h7777);
    rd_op(16'h0080);
    idle(Lat + 1);

    // Write then read after two idle cycles.
    wr_op(16'h0010, 16'h1234);
    idle(2);
    rd_op(16'h0010);
    idle(Lat + 1);

    // Eight-word line fill, back to back.
    for (int i = 0; i < 8; i++) wr_op(16'(16'h0020 + i * 2), 16'(16'hA000 + i));
    for (int i = 0; i < 8; i++) rd_op(16'(16'h0020 + i * 2));
    idle(Lat + 2);

    // Read snapshot versus a following write to the same word.
    wr_op(16'h0040, 16'h1111);
    rd_op(16'h0040);
    wr_op(16'h0040, 16'h2222);
    rd_op(16'h0040);
    idle(Lat + 1);

    // Bubbles are preserved cycle for cycle.
    rd_op(16'h0010);
    idle(1);
    rd_op(16'h0020);
    rd_op(16'h0022);
    idle(Lat + 1);

    // Reset at the third response of a six-read burst, then confirm contents survive.
    for (int i = 0; i < 6; i++) rd_op(16'(16'h0020 + i * 2));
    step(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(Lat + 1);
    rd_op(16'h0020);
    rd_op(16'h002E);
    rd_op(16'h0010);
    idle(Lat + 1);

    // Aliasing of upper address bits and the ignored byte bit.
    wr_op(16'h4010, 16'hBEEF);
    rd_op(16'h0010);
    rd_op(16'h0011);
    idle(Lat + 1);

    // Random mix inside the preloaded window, with random alias bits and occasional reset.
    for (int i = 0; i < 600; i++) begin
      a = 16'(($urandom_range(0, 3) << 14) | ($urandom_range(0, 63) << 1) | $urandom_range(0, 1));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), a, 16'($urandom));
    end
    idle(Lat + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_burst_responder.md
# memory_burst_responder

Multi-cycle word-addressed memory model that sits on the memory side of the cache-fill interface, answering the address stream produced by the cache fill FSM. It accepts one read or write request per cycle. Read data returns a fixed number of cycles later with `memory_data_valid`, so an 8-word line fill can be issued back-to-back and returned in order. A `busy` flag reports in-flight reads.

## Interface
- `ADDR_W`, 16, byte-address width.
- `DATA_W`, 16, word width.
- `DEPTH_LOG2`, 13, log2 of array depth in words; word index = `address[DEPTH_LOG2:1]`.
- `LATENCY`, 4, read latency in cycles; legal range 1..8.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  request strobe, sampled every rising edge.
- `wr`  in  1  with `enable`: 1 = write, 0 = read.
- `address`  in  ADDR_W  byte address; bit 0 ignored.
- `data_in`  in  DATA_W  write data.
- `memory_data`  out  DATA_W  read data.
- `memory_data_valid`  out  1  high for exactly one cycle per read, same cycle as `memory_data`.
- `busy`  out  1  high while any read is in flight.

## Operation
- Storage: 2^DEPTH_LOG2 words of DATA_W bits. Address bits above DEPTH_LOG2 are ignored, so upper addresses alias to lower ones. Contents are not cleared by `rst`; the array powers up as X in simulation.
- Write (`enable`=1, `wr`=1): the array word is updated at the sampling edge. A write produces no response and does not touch the pipeline.
- Read (`enable`=1, `wr`=0): the array word is read at the sampling edge. The word, together with a valid bit, enters stage 1 of a LATENCY-deep delay pipeline. Each stage advances every cycle, and the pipeline never stalls.
- Read data is a snapshot taken at issue. A write issued after a read, including one to the same address, does not change that read's returned data.
- `enable`=0 inserts a bubble (valid=0) into stage 1.
- Responses return in issue order. Holes in the request stream are preserved cycle for cycle.
- `memory_data_valid` = final-stage valid bit.
- `memory_data` = final-stage data when valid, and 0 otherwise. It never presents stale data.
- `busy` = OR of all stage valid bits, registered alongside the stages.
- Reset, including mid-burst: all stage valid bits and data go to 0, and in-flight reads are discarded without response. Writes completed before the reset edge persist. A request sampled on the same edge as `rst`=1 is ignored; no write occurs.
- `wr` and `data_in` are don't-care when `enable`=0.

## Timing
- Reset values: `memory_data`=0, `memory_data_valid`=0, `busy`=0, visible the cycle after the reset edge.
- Read sampled at edge E0: `memory_data_valid`=1 in the cycle following edge E0+LATENCY-1.
  - LATENCY=1 behaves as a registered read, with data in the cycle after the request.
  - LATENCY=4: request in cycle 0, data in cycle 4.
- Throughput: one read per cycle sustained. N back-to-back reads produce N consecutive valid cycles.
- `busy` rises the cycle after the first read edge. It falls in the cycle after the last response's valid cycle, unless another read is still in flight.
- A write at edge E is visible to a read sampled at edge E+1 or later.

## Structure
- Shared package `mem_pkg`:
  - `MEM_ADDR_W`=16, `MEM_DATA_W`=16, `MEM_LATENCY`=4.
  - `mem_resp_t` struct: `valid` (1 bit) plus `data` (DATA_W).
  - The cache fill FSM also imports these constants.
- Sub-module `mem_delay_pipe`: parameterized LATENCY-stage shift register of `mem_resp_t` with synchronous clear. It also provides the OR-of-valids used for `busy`.
- The array and request decode stay in the top module.

## Test plan
- Write/read: write 0x1234 to 0x0010, idle 2 cycles, read 0x0010 → `memory_data_valid`=1 with `memory_data`=0x1234 exactly 4 cycles after the read; `busy` high for cycles 1–4.
- Line fill: preload 0x0020..0x002E with 0xA000+index, then issue 8 back-to-back reads stepping address by 2 → 8 consecutive valid cycles, data 0xA000..0xA007 in order, `busy` falls one cycle after the last.
- Read then write same address: 0x0040 holds 0x1111; read 0x0040, then next cycle write 0x2222 → read returns 0x1111; a later read returns 0x2222.
- Bubbles: reads in cycles 0, 2, 3 → valid in cycles 4, 6, 7 only, and `memory_data`=0 in cycle 5.
- Reset mid-burst: issue 6 reads and assert `rst` at the third response → valid=0 and `busy`=0 the next cycle, no further responses, and earlier-written contents intact on re-read.
- Aliasing: with DEPTH_LOG2=13, write 0xBEEF to 0x4010, then read 0x0010 and 0x0011 → both return 0xBEEF.
